// File: rtl/lives_pkg.sv
// Shared types and constants for the lives_manager block.
package lives_pkg;

   localparam int unsigned FRAME_CNT_W = 8;
   localparam int unsigned LIVES_W     = 3;
   localparam int unsigned DRAW_W      = 10;

   typedef logic [LIVES_W-1:0]     lives_t;
   typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

   typedef enum logic [1:0] {
      ALIVE  = 2'd0,
      FREEZE = 2'd1,
      INVULN = 2'd2,
      OVER   = 2'd3
   } lives_state_t;

   // Frame counter increment that sticks at all-ones instead of wrapping.
   function automatic frame_cnt_t frame_cnt_inc(input frame_cnt_t cnt);
      return (cnt == '1) ? cnt : cnt + frame_cnt_t'(1);
   endfunction

   // Add one life, clamped at the ceiling.
   function automatic lives_t lives_inc_sat(input lives_t cur, input lives_t ceil);
      return (cur < ceil) ? cur + lives_t'(1) : cur;
   endfunction

   // Remove one life, never going below zero.
   function automatic lives_t lives_dec_sat(input lives_t cur);
      return (cur == '0) ? cur : cur - lives_t'(1);
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick on the rising edge of the (0,0) scan position.
module frame_tick_gen
   import lives_pkg::*;
(
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic [DRAW_W-1:0] DrawX,
   input  logic [DRAW_W-1:0] DrawY,
   output logic              frame_tick
);

   logic origin_d, origin_q;
   logic tick_d, tick_q;

   // Detect the first cycle the scan sits on the origin pixel.
   always_comb begin
      origin_d = (DrawX == '0) && (DrawY == '0);
      tick_d   = origin_d && !origin_q;
   end

   // Edge-detect history and the registered tick.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         origin_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         origin_q <= origin_d;
         tick_q   <= tick_d;
      end
   end

   assign frame_tick = tick_q;

endmodule

// File: rtl/lives_manager.sv
// Player life count and hit/freeze/invulnerability/game-over sequencing.
// Optional sprite blink during invulnerability: define LIVES_BLINK_EN.
module lives_manager
   import lives_pkg::*;
#(
   parameter int unsigned START_LIVES   = 3,
   parameter int unsigned MAX_LIVES     = 3,
   parameter int unsigned FREEZE_FRAMES = 60,
   parameter int unsigned INVULN_FRAMES = 120
)(
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic [DRAW_W-1:0]  DrawX,
   input  logic [DRAW_W-1:0]  DrawY,
   input  logic               hit,
   input  logic               bonus,
   input  logic               new_game,
   output logic [LIVES_W-1:0] lives,
   output logic               freeze,
   output logic               invuln,
   output logic               game_over,
   output logic               life_lost,
   output logic               lives_blank
);

   localparam lives_t     START_L  = lives_t'(START_LIVES);
   localparam lives_t     MAX_L    = lives_t'(MAX_LIVES);
   localparam frame_cnt_t FREEZE_N = frame_cnt_t'(FREEZE_FRAMES);
   localparam frame_cnt_t INVULN_N = frame_cnt_t'(INVULN_FRAMES);

   logic         frame_tick;
   lives_state_t state_d, state_q;
   frame_cnt_t   frame_cnt_d, frame_cnt_q;
   lives_t       lives_d, lives_q;
   logic         last_life_d, last_life_q;
   logic         life_lost_d, life_lost_q;
   frame_cnt_t   cnt_next;

   frame_tick_gen u_frame_tick_gen (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .frame_tick (frame_tick)
   );

   // State register.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ALIVE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: frame counter, life count, last-life flag, hit pulse.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= '0;
         lives_q     <= START_L;
         last_life_q <= 1'b0;
         life_lost_q <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         lives_q     <= lives_d;
         last_life_q <= last_life_d;
         life_lost_q <= life_lost_d;
      end
   end

   // Next-state and datapath update; new_game beats everything else.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      lives_d     = lives_q;
      last_life_d = last_life_q;
      life_lost_d = 1'b0;
      cnt_next    = frame_cnt_inc(frame_cnt_q);

      if (new_game) begin
         state_d     = ALIVE;
         frame_cnt_d = '0;
         lives_d     = START_L;
         last_life_d = 1'b0;
      end else begin
         case (state_q)
            ALIVE: begin
               if (hit) begin
                  state_d     = FREEZE;
                  frame_cnt_d = '0;
                  life_lost_d = 1'b1;
                  // A same-cycle bonus is applied after the loss, so at zero
                  // lives it rescues the player from the final life.
                  last_life_d = (lives_q == '0) && !bonus;
                  lives_d     = bonus ? lives_inc_sat(lives_dec_sat(lives_q), MAX_L)
                                      : lives_dec_sat(lives_q);
               end else if (bonus) begin
                  lives_d = lives_inc_sat(lives_q, MAX_L);
               end
            end
            FREEZE: begin
               if (bonus) begin
                  lives_d = lives_inc_sat(lives_q, MAX_L);
               end
               if (frame_tick) begin
                  if (cnt_next == FREEZE_N) begin
                     frame_cnt_d = '0;
                     state_d     = last_life_q ? OVER : INVULN;
                  end else begin
                     frame_cnt_d = cnt_next;
                  end
               end
            end
            INVULN: begin
               if (bonus) begin
                  lives_d = lives_inc_sat(lives_q, MAX_L);
               end
               if (frame_tick) begin
                  if (cnt_next == INVULN_N) begin
                     frame_cnt_d = '0;
                     state_d     = ALIVE;
                  end else begin
                     frame_cnt_d = cnt_next;
                  end
               end
            end
            OVER: begin
               state_d = OVER;
            end
            default: begin
               state_d = ALIVE;
            end
         endcase
      end
   end

   // Output decode from registered state.
   always_comb begin
      freeze      = 1'b0;
      invuln      = 1'b0;
      game_over   = 1'b0;
      lives_blank = 1'b0;
      case (state_q)
         FREEZE:  freeze    = 1'b1;
         INVULN:  invuln    = 1'b1;
         OVER:    game_over = 1'b1;
         default: ;
      endcase
`ifdef LIVES_BLINK_EN
      // Bit 3 of the frame count flips every 8 frames of invulnerability.
      if (state_q == INVULN) begin
         lives_blank = frame_cnt_q[3];
      end
`endif
   end

   assign lives     = lives_q;
   assign life_lost = life_lost_q;

endmodule

// File: tb/tb_lives_manager.sv
// Directed bench for lives_manager: vector table plus multi-cycle sequences.
module tb_lives_manager;

`ifdef LIVES_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic [9:0] DrawX, DrawY;
   logic       hit, bonus, new_game;
   logic [2:0] lives;
   logic       freeze, invuln, game_over, life_lost, lives_blank;

   int n_cmp = 0;
   int n_bad = 0;
   int ll_count = 0;

   typedef struct {
      bit       hit;
      bit       bonus;
      bit       new_game;
      int       frames;
      bit [2:0] lives;
      bit       frz;
      bit       inv;
      bit       ovr;
      bit       ll;
   } vec_t;

   vec_t tbl[$];

   always #5 vga_clk = ~vga_clk;

   lives_manager #(
      .START_LIVES   (3),
      .MAX_LIVES     (3),
      .FREEZE_FRAMES (60),
      .INVULN_FRAMES (120)
   ) dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .hit         (hit),
      .bonus       (bonus),
      .new_game    (new_game),
      .lives       (lives),
      .freeze      (freeze),
      .invuln      (invuln),
      .game_over   (game_over),
      .life_lost   (life_lost),
      .lives_blank (lives_blank)
   );

   // Count life_lost pulses, sampled mid-cycle.
   always @(negedge vga_clk) begin
      if (life_lost === 1'b1) ll_count++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int l, input bit fr, input bit iv,
                             input bit ov, input bit ll);
      check({tag, " lives"}, 32'(lives), 32'(l));
      check({tag, " freeze"}, 32'(freeze), 32'(fr));
      check({tag, " invuln"}, 32'(invuln), 32'(iv));
      check({tag, " game_over"}, 32'(game_over), 32'(ov));
      check({tag, " life_lost"}, 32'(life_lost), 32'(ll));
   endtask

   // One frame: origin pixel for a cycle, then away; returns after the tick is consumed.
   task automatic frame();
      DrawX = 10'd0;
      DrawY = 10'd0;
      @(negedge vga_clk);
      DrawX = 10'd5;
      DrawY = 10'd5;
      @(negedge vga_clk);
      @(negedge vga_clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic pulse(input bit h, input bit b, input bit ng);
      hit      = h;
      bonus    = b;
      new_game = ng;
      @(negedge vga_clk);
      hit      = 1'b0;
      bonus    = 1'b0;
      new_game = 1'b0;
   endtask

   function automatic vec_t mk(input bit h, input bit b, input bit ng, input int f,
                               input int l, input bit fr, input bit iv, input bit ov,
                               input bit ll);
      vec_t v;
      v.hit = h; v.bonus = b; v.new_game = ng; v.frames = f;
      v.lives = 3'(l); v.frz = fr; v.inv = iv; v.ovr = ov; v.ll = ll;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      //        hit bon ng  frm  lv frz inv ovr ll
      tbl.push_back(mk(0, 0, 0,   1, 3, 0, 0, 0, 0)); // idle frame, no change
      tbl.push_back(mk(1, 0, 0,   0, 2, 1, 0, 0, 1)); // hit
      tbl.push_back(mk(0, 0, 0,  59, 2, 1, 0, 0, 0)); // still frozen at tick 59
      tbl.push_back(mk(0, 0, 0,   1, 2, 0, 1, 0, 0)); // tick 60 -> invuln
      tbl.push_back(mk(0, 1, 0,   0, 3, 0, 1, 0, 0)); // bonus in invuln
      tbl.push_back(mk(0, 1, 0,   0, 3, 0, 1, 0, 0)); // saturates
      tbl.push_back(mk(0, 0, 0, 119, 3, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0,   1, 3, 0, 0, 0, 0)); // tick 120 -> alive
      tbl.push_back(mk(0, 1, 0,   0, 3, 0, 0, 0, 0)); // saturates in alive
      tbl.push_back(mk(1, 1, 0,   0, 3, 1, 0, 0, 1)); // hit+bonus net zero
      tbl.push_back(mk(0, 0, 1,   0, 3, 0, 0, 0, 0)); // new_game from freeze
      tbl.push_back(mk(1, 0, 0,   0, 2, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,   0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,   0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,   0, 0, 1, 0, 0, 1)); // hit at zero: last life
      tbl.push_back(mk(0, 0, 0,  59, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,   1, 0, 0, 0, 1, 0)); // game over
      tbl.push_back(mk(0, 1, 0,   0, 0, 0, 0, 1, 0)); // bonus ignored
      tbl.push_back(mk(1, 0, 0,   0, 0, 0, 0, 1, 0)); // hit ignored
      tbl.push_back(mk(0, 0, 0, 200, 0, 0, 0, 1, 0)); // waits
      tbl.push_back(mk(1, 0, 1,   0, 3, 0, 0, 0, 0)); // new_game beats hit
      tbl.push_back(mk(1, 0, 0,   0, 2, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,   0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0,   0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 180, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0,   0, 1, 1, 0, 0, 1)); // hit+bonus at zero
      tbl.push_back(mk(0, 0, 0,  60, 1, 0, 1, 0, 0)); // invuln, not over
      tbl.push_back(mk(0, 0, 0, 120, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0,   0, 2, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1,   0, 3, 0, 0, 0, 0)); // new_game beats both

      reset_n  = 1'b0;
      hit      = 1'b0;
      bonus    = 1'b0;
      new_game = 1'b0;
      DrawX    = 10'd5;
      DrawY    = 10'd5;
      repeat (3) @(negedge vga_clk);
      check_outs("in_reset", 3, 0, 0, 0, 0);
      check("in_reset lives_blank", 32'(lives_blank), 0);
      reset_n = 1'b1;
      @(negedge vga_clk);
      check_outs("after_reset", 3, 0, 0, 0, 0);

      foreach (tbl[i]) begin
         pulse(tbl[i].hit, tbl[i].bonus, tbl[i].new_game);
         frames(tbl[i].frames);
         check_outs($sformatf("row%0d", i), tbl[i].lives, tbl[i].frz, tbl[i].inv,
                    tbl[i].ovr, tbl[i].ll);
         if (!tbl[i].inv) check($sformatf("row%0d lives_blank", i), 32'(lives_blank), 0);
      end

      // hit held 500 cycles: one accepted hit, full freeze and invuln, blink pattern.
      base = ll_count;
      fork
         begin
            hit = 1'b1;
            repeat (500) @(negedge vga_clk);
            hit = 1'b0;
         end
         begin
            @(negedge vga_clk);
            check_outs("held_hit", 2, 1, 0, 0, 1);
            frames(59);
            check_outs("held_f59", 2, 1, 0, 0, 0);
            check("held_f59 lives_blank", 32'(lives_blank), 0);
            frame();
            check_outs("held_inv0", 2, 0, 1, 0, 0);
            check("blank k0", 32'(lives_blank), 0);
            for (int k = 1; k < 120; k++) begin
               frame();
               check($sformatf("invuln k%0d", k), 32'(invuln), 1);
               check($sformatf("blank k%0d", k), 32'(lives_blank),
                     BLINK ? 32'((k >> 3) & 1) : 32'd0);
            end
            frame();
            check_outs("held_alive", 2, 0, 0, 0, 0);
            check("held_alive lives_blank", 32'(lives_blank), 0);
         end
      join
      repeat (4) @(negedge vga_clk);
      check("held_hit pulse count", 32'(ll_count - base), 1);
      check_outs("held_settle", 2, 0, 0, 0, 0);

      // hit still high when invuln ends: accepted the cycle after re-entering alive.
      hit = 1'b1;
      @(negedge vga_clk);
      check_outs("reentry_hit", 1, 1, 0, 0, 1);
      frames(60);
      check_outs("reentry_inv", 1, 0, 1, 0, 0);
      frames(119);
      DrawX = 10'd0;
      DrawY = 10'd0;
      @(negedge vga_clk);
      DrawX = 10'd5;
      DrawY = 10'd5;
      @(negedge vga_clk);
      check_outs("reentry_alive", 1, 0, 0, 0, 0);
      @(negedge vga_clk);
      check_outs("reentry_rehit", 0, 1, 0, 0, 1);
      hit = 1'b0;

      // new_game at tick 30 of a freeze.
      frames(30);
      check_outs("ng_f30", 0, 1, 0, 0, 0);
      pulse(0, 0, 1);
      check_outs("ng_alive", 3, 0, 0, 0, 0);

      // Asynchronous reset mid-freeze.
      pulse(1, 0, 0);
      frames(10);
      check_outs("pre_rst", 2, 1, 0, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check_outs("async_rst", 3, 0, 0, 0, 0);
      @(negedge vga_clk);
      reset_n = 1'b1;
      @(negedge vga_clk);
      frames(60);
      check_outs("post_rst", 3, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
